// File: rtl/prism_byte_data_unstuffer.sv
// rtl/prism_byte_data_unstuffer.sv - realigns a dense little-endian byte stream onto a destination lane offset
module prism_byte_data_unstuffer #(
  parameter int DATA_WIDTH = 64,
  parameter int OFF_WIDTH  = $clog2(DATA_WIDTH/8),
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  i_start,
  output logic                  o_start_ready,
  input  logic [OFF_WIDTH-1:0]  i_offset,
  input  logic [LEN_WIDTH-1:0]  i_length,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  i_eof,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [OFF_WIDTH-1:0]  o_lsbyte,
  output logic [OFF_WIDTH-1:0]  o_msbyte,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_done,
  output logic                  o_len_error
);
  localparam int N  = DATA_WIDTH / 8;
  localparam int CW = OFF_WIDTH + 1;
  localparam logic [CW-1:0]        N_LANES = CW'(N);
  localparam logic [LEN_WIDTH-1:0] N_LEN   = LEN_WIDTH'(N);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [OFF_WIDTH-1:0]  off_q;
  logic [OFF_WIDTH-1:0]  held_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  words_q;
  logic                  first_q;
  logic [DATA_WIDTH-1:0] res_q;

  logic                  advance, need_word, take_word, beat_fire, eof_xfer;
  logic [CW-1:0]         avail, rem_cap, cnt;
  logic [OFF_WIDTH-1:0]  lsb, msb;
  logic [DATA_WIDTH-1:0] aligned, raw, beat_data, res_next;

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start && i_length != '0) state_d = ST_RUN;
      ST_RUN: begin
        if (eof_xfer)
          state_d = ST_IDLE;
        else if (take_word && words_q == LEN_WIDTH'(1) && rem_q != LEN_WIDTH'(cnt))
          state_d = ST_FLUSH;
      end
      ST_FLUSH: if (eof_xfer) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_start_ready = (state_q == ST_IDLE);
    advance       = !o_valid || o_ready;
    need_word     = first_q || (rem_q > LEN_WIDTH'(held_q));
    i_ready       = (state_q == ST_RUN) && (words_q != '0) && advance && need_word;
    take_word     = i_ready && i_valid;
    beat_fire     = take_word ||
                    ((state_q != ST_IDLE) && (rem_q != '0) && advance && !need_word);
    eof_xfer      = o_valid && o_ready && o_eof;

    avail   = N_LANES - CW'(off_q);
    rem_cap = (rem_q >= N_LEN) ? N_LANES : rem_q[CW-1:0];
    if (first_q) begin
      cnt = (rem_q >= LEN_WIDTH'(avail)) ? avail : rem_q[CW-1:0];
      lsb = off_q;
    end else begin
      // a flush beat always has rem below N, so rem_cap is the exact count
      cnt = rem_cap;
      lsb = '0;
    end
    msb = OFF_WIDTH'(CW'(lsb) + cnt - CW'(1));

    // residual is empty before the first word, so one expression covers both word beats
    aligned  = i_data << {off_q, 3'b000};
    raw      = need_word ? (res_q | aligned) : res_q;
    res_next = i_data >> {avail, 3'b000};

    beat_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(lsb) && i <= int'(msb))
        beat_data[i*8 +: 8] = raw[i*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      off_q       <= '0;
      held_q      <= '0;
      rem_q       <= '0;
      words_q     <= '0;
      first_q     <= 1'b0;
      res_q       <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_lsbyte    <= '0;
      o_msbyte    <= '0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_done      <= 1'b0;
      o_len_error <= 1'b0;
    end else begin
      o_done      <= eof_xfer;
      o_len_error <= 1'b0;
      if (o_valid && o_ready)
        o_valid <= 1'b0;

      if (state_q == ST_IDLE && i_start) begin
        off_q   <= i_offset;
        held_q  <= '0;
        rem_q   <= i_length;
        words_q <= LEN_WIDTH'(({1'b0, i_length} + (LEN_WIDTH+1)'(N - 1)) >> OFF_WIDTH);
        first_q <= 1'b1;
        res_q   <= '0;
        if (i_length == '0)
          o_done <= 1'b1;
      end

      if (beat_fire) begin
        o_valid  <= 1'b1;
        o_data   <= beat_data;
        o_lsbyte <= lsb;
        o_msbyte <= msb;
        o_sof    <= first_q;
        o_eof    <= (rem_q == LEN_WIDTH'(cnt));
        rem_q    <= rem_q - LEN_WIDTH'(cnt);
        first_q  <= 1'b0;
        held_q   <= off_q;
      end

      if (take_word) begin
        res_q       <= res_next;
        words_q     <= words_q - LEN_WIDTH'(1);
        o_len_error <= (words_q > LEN_WIDTH'(1) && i_eof) ||
                       (words_q == LEN_WIDTH'(1) && !i_eof);
      end
    end
  end
endmodule
